// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler
//   Polls two NES controller pads over a shared latch/pulse pair. A poll can
//   be started on demand or by the periodic auto-poll timer. Each poll holds
//   latch high, then clocks in 8 serial bits per pad. At the end it publishes
//   both button bytes and their change masks together with a one-cycle strobe.
//
// Parameters
//   LATCH_CYCLES  latch high time in clocks
//   HALF_CYCLES   pulse half-period in clocks
//   PERIOD        auto-poll period in clocks (20-bit timer)
//
// Ports
//   clock              rising-edge system clock
//   reset              synchronous, active-high reset
//   auto_en            enables periodic polling
//   poll_req           one-cycle on-demand poll request
//   data0 / data1      serial pad data, active low, asynchronous
//   latch / pulse      shared latch and clock lines to both pads
//   buttons0/buttons1  pad state, active high (7=A 6=B 5=Sel 4=Start 3=Up 2=Dn 1=L 0=R)
//   changed0/changed1  XOR of new and previous button bytes
//   valid              one-cycle strobe: buttons/changed just updated
//   busy               high whenever the scheduler is not idle
module nes_poll_scheduler #(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned PERIOD       = 833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       auto_en,
  input  logic       poll_req,
  input  logic       data0,
  input  logic       data1,
  output logic       latch,
  output logic       pulse,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic [7:0] changed0,
  output logic [7:0] changed1,
  output logic       valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
  localparam logic [19:0]   TIMER_LAST = 20'(PERIOD - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [19:0]   timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [1:0]    sync0_q, sync1_q;
  logic [7:0]    shift0_q, shift0_d, shift1_q, shift1_d;
  logic [7:0]    buttons0_q, buttons0_d, buttons1_q, buttons1_d;
  logic [7:0]    changed0_q, changed0_d, changed1_q, changed1_d;
  logic          wrap, start, sd0, sd1;

  assign sd0 = sync0_q[1];
  assign sd1 = sync1_q[1];

  // Pad data is asynchronous to clock; only the second flop is ever sampled.
  always_ff @(posedge clock) begin
    sync0_q <= {sync0_q[0], data0};
    sync1_q <= {sync1_q[0], data1};
  end

  always_comb begin
    wrap    = auto_en && (timer_q == TIMER_LAST);
    timer_d = '0;
    if (auto_en && !wrap) begin
      timer_d = timer_q + 20'd1;
    end
  end

  assign start = poll_req | wrap | pending_q;

  // Events arriving while a poll runs collapse into one deferred poll; the
  // flag is consumed on leaving IDLE.
  assign pending_d = (state_q == S_IDLE) ? 1'b0 : (pending_q | poll_req | wrap);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shift0_d   = shift0_q;
    shift1_d   = shift1_q;
    buttons0_d = buttons0_q;
    buttons1_d = buttons1_q;
    changed0_d = changed0_q;
    changed1_d = changed1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LATCH;
          phase_d = '0;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = S_LOW;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LOW: begin
        if (phase_q == HALF_LAST) begin
          shift0_d[3'd7 - bit_q] = ~sd0;
          shift1_d[3'd7 - bit_q] = ~sd1;
          phase_d = '0;
          if (bit_q == 3'd7) begin
            // Outputs load on the edge into DONE so the new bytes are
            // already visible during the valid cycle.
            state_d    = S_DONE;
            buttons0_d = shift0_d;
            buttons1_d = shift1_d;
            changed0_d = shift0_d ^ buttons0_q;
            changed1_d = shift1_d ^ buttons1_q;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == HALF_LAST) begin
          state_d = S_LOW;
          phase_d = '0;
          bit_d   = bit_q + 3'd1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      shift0_q   <= '0;
      shift1_q   <= '0;
      buttons0_q <= '0;
      buttons1_q <= '0;
      changed0_q <= '0;
      changed1_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      shift0_q   <= shift0_d;
      shift1_q   <= shift1_d;
      buttons0_q <= buttons0_d;
      buttons1_q <= buttons1_d;
      changed0_q <= changed0_d;
      changed1_q <= changed1_d;
    end
  end

  assign latch    = (state_q == S_LATCH);
  assign pulse    = (state_q != S_LOW);
  assign valid    = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign buttons0 = buttons0_q;
  assign buttons1 = buttons1_q;
  assign changed0 = changed0_q;
  assign changed1 = changed1_q;

endmodule
